frontend_width_ctrl: RTL

//  Sequences runtime changes of the fetch/pre-decode front-end width (1..4 lanes) for the Flicker cores.

---
 rtl/frontend_pkg.sv | 30 +++
 rtl/frontend_width_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/frontend_pkg.sv
// Shared front-end width definitions: FSM states, width limits and the
// width -> lane mask decode that FetchStage2 also uses.
package frontend_pkg;

  localparam int MAX_FE_WIDTH  = 4;
  localparam int FE_WIDTH_BITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } fe_state_e;

  // Lanes are enabled from the top (lane 3) downwards; illegal -> no lanes.
  function automatic logic [MAX_FE_WIDTH-1:0] width_to_mask(
    input logic [FE_WIDTH_BITS-1:0] width
  );
    logic [MAX_FE_WIDTH-1:0] m;
    case (width)
      3'd4:    m = 4'b1111;
      3'd3:    m = 4'b1110;
      3'd2:    m = 4'b1100;
      3'd1:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/frontend_width_ctrl.sv
// Sequences runtime front-end width changes: stall, drain, apply, settle, ack.
// Ports: clk/reset (async, active-low); cfgReq_i/cfgWidth_i request;
//   instValid_i, recoverFlag_i, flagRecoverEX_i pipeline activity;
//   frontEndWidth_o/frontEndMask_o applied width; fetchStall_o, busy_o,
//   cfgAck_o / cfgErr_o one-cycle completion pulses.
module frontend_width_ctrl
  import frontend_pkg::*;
#(
  parameter int unsigned DEFAULT_WIDTH  = 4,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfgReq_i,
  input  logic [FE_WIDTH_BITS-1:0] cfgWidth_i,
  input  logic [MAX_FE_WIDTH-1:0]  instValid_i,
  input  logic                     recoverFlag_i,
  input  logic                     flagRecoverEX_i,
  output logic [FE_WIDTH_BITS-1:0] frontEndWidth_o,
  output logic [MAX_FE_WIDTH-1:0]  frontEndMask_o,
  output logic                     fetchStall_o,
  output logic                     busy_o,
  output logic                     cfgAck_o,
  output logic                     cfgErr_o
);

  localparam int DCW = $clog2(DRAIN_CYCLES) + 1;
  localparam int SCW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [SCW-1:0] SET_LAST   = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [FE_WIDTH_BITS-1:0] DEF_W = FE_WIDTH_BITS'(DEFAULT_WIDTH);

  fe_state_e state_q, state_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [SCW-1:0] set_q, set_d;
  logic [TCW-1:0] to_q, to_d;
  logic [FE_WIDTH_BITS-1:0] pend_q, pend_d;
  logic [FE_WIDTH_BITS-1:0] width_q, width_d;
  logic [MAX_FE_WIDTH-1:0] mask_q, mask_d;
  logic stall_q, stall_d;
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic quiet;
  logic req_legal;

  assign quiet = (instValid_i == '0) & ~recoverFlag_i & ~flagRecoverEX_i;
  // Any width with a non-empty mask is legal (1..4).
  assign req_legal = |width_to_mask(cfgWidth_i);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    set_d   = set_q;
    to_d    = to_q;
    pend_d  = pend_q;
    width_d = width_q;
    mask_d  = mask_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfgReq_i) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (cfgWidth_i == width_q) begin
            ack_d = 1'b1;
          end else begin
            pend_d  = cfgWidth_i;
            drain_d = '0;
            to_d    = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        to_d    = to_q + 1'b1;
        drain_d = quiet ? drain_q + 1'b1 : '0;
        // Apply takes priority over a coincident timeout.
        if (quiet && drain_q == DRAIN_LAST) begin
          state_d = APPLY;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      APPLY: begin
        width_d = pend_q;
        mask_d  = width_to_mask(pend_q);
        set_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        set_d = set_q + 1'b1;
        if (set_q == SET_LAST) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Stall/busy are registered from the next state so they drop with ack.
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      set_q   <= '0;
      to_q    <= '0;
      pend_q  <= DEF_W;
      width_q <= DEF_W;
      mask_q  <= width_to_mask(DEF_W);
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      set_q   <= set_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
      width_q <= width_d;
      mask_q  <= mask_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign frontEndWidth_o = width_q;
  assign frontEndMask_o  = mask_q;
  assign fetchStall_o    = stall_q;
  assign busy_o          = stall_q;
  assign cfgAck_o        = ack_q;
  assign cfgErr_o        = err_q;

endmodule
